// File: rtl/bira_pkg.sv
// Shared BIRA repair-analysis constants and types: spare word geometry, generator states,
// and the first/last candidate patterns used by the generator, the checker and benches.
package bira_pkg;

  localparam int DSSS_WIDTH    = 8;
  localparam int DSSS_SET_BITS = 4;
  localparam int RLSS_WIDTH    = 4;
  localparam int RLSS_SET_BITS = 2;
  localparam int PAIR_IDX_W    = 9;

  // C(8,4) * C(4,2)
  localparam int NUM_PAIRS = 420;

  localparam logic [DSSS_WIDTH-1:0] DSSS_FIRST = 8'h0F;
  localparam logic [DSSS_WIDTH-1:0] DSSS_LAST  = 8'hF0;
  localparam logic [RLSS_WIDTH-1:0] RLSS_FIRST = 4'h3;
  localparam logic [RLSS_WIDTH-1:0] RLSS_LAST  = 4'hC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gen_state_t;

endpackage

// File: rtl/combo_next.sv
// Gosper's next-combination step: returns the next larger W-bit word with the same popcount.
// The successor of the topmost pattern is meaningless; callers never consume it.
module combo_next #(
  parameter int W = 8
) (
  input  logic [W-1:0] cur,
  output logic [W-1:0] nxt
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  lowbit;
  logic [W-1:0]  ripple;
  logic [W-1:0]  tail;
  logic [CW-1:0] ctz;

  // Lowest set bit ripples upward; the displaced ones are packed back at the bottom.
  always_comb begin
    lowbit = cur & (~cur + 1'b1);
    ripple = cur + lowbit;
    ctz    = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (lowbit[i]) ctz = CW'(i);
    end
    tail = ((ripple ^ cur) >> 2) >> ctz;
    nxt  = tail | ripple;
  end

endmodule

// File: rtl/spare_signal_generator.sv
// Enumerates every DSSS/RLSS spare-allocation pair, one per valid/ready handshake.
// Optional early termination (stop/stopped ports) is enabled by defining SPARE_GEN_EARLY_STOP_EN.
module spare_signal_generator
  import bira_pkg::*;
#(
  parameter int DSSS_W    = DSSS_WIDTH,
  parameter int DSSS_ONES = DSSS_SET_BITS,
  parameter int RLSS_W    = RLSS_WIDTH,
  parameter int RLSS_ONES = RLSS_SET_BITS,
  parameter int IDX_W     = PAIR_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              out_ready,
`ifdef SPARE_GEN_EARLY_STOP_EN
  input  logic              stop,
  output logic              stopped,
`endif
  output logic [DSSS_W-1:0] DSSS,
  output logic [RLSS_W-1:0] RLSS,
  output logic              out_valid,
  output logic              out_last,
  output logic [IDX_W-1:0]  pair_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [DSSS_W-1:0] D_FIRST = {{(DSSS_W-DSSS_ONES){1'b0}}, {DSSS_ONES{1'b1}}};
  localparam logic [DSSS_W-1:0] D_LAST  = {{DSSS_ONES{1'b1}}, {(DSSS_W-DSSS_ONES){1'b0}}};
  localparam logic [RLSS_W-1:0] R_FIRST = {{(RLSS_W-RLSS_ONES){1'b0}}, {RLSS_ONES{1'b1}}};
  localparam logic [RLSS_W-1:0] R_LAST  = {{RLSS_ONES{1'b1}}, {(RLSS_W-RLSS_ONES){1'b0}}};

  gen_state_t        state, state_nxt;
  logic [DSSS_W-1:0] dsss_nxt, dsss_succ;
  logic [RLSS_W-1:0] rlss_nxt, rlss_succ;
  logic [IDX_W-1:0]  idx_nxt;
  logic              last_nxt;
  logic              stop_req;
  logic              stopped_q, stopped_nxt;

  combo_next #(.W(DSSS_W)) u_dsss_next (.cur(DSSS), .nxt(dsss_succ));
  combo_next #(.W(RLSS_W)) u_rlss_next (.cur(RLSS), .nxt(rlss_succ));

`ifdef SPARE_GEN_EARLY_STOP_EN
  assign stop_req = stop;
  assign stopped  = stopped_q;
`else
  assign stop_req = 1'b0;
`endif

  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      DSSS      <= '0;
      RLSS      <= '0;
      pair_idx  <= '0;
      out_last  <= 1'b0;
      stopped_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      DSSS      <= dsss_nxt;
      RLSS      <= rlss_nxt;
      pair_idx  <= idx_nxt;
      out_last  <= last_nxt;
      stopped_q <= stopped_nxt;
    end
  end

  // RLSS is the inner loop; ending the sweep (last pair or stop) freezes the pair outputs.
  always_comb begin
    state_nxt   = state;
    dsss_nxt    = DSSS;
    rlss_nxt    = RLSS;
    idx_nxt     = pair_idx;
    stopped_nxt = stopped_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = RUN;
          dsss_nxt    = D_FIRST;
          rlss_nxt    = R_FIRST;
          idx_nxt     = '0;
          stopped_nxt = 1'b0;
        end
      end
      RUN: begin
        if (stop_req) begin
          state_nxt   = DONE;
          stopped_nxt = 1'b1;
        end else if (out_ready) begin
          if (out_last) begin
            state_nxt = DONE;
          end else begin
            idx_nxt = pair_idx + 1'b1;
            if (RLSS == R_LAST) begin
              rlss_nxt = R_FIRST;
              dsss_nxt = dsss_succ;
            end else begin
              rlss_nxt = rlss_succ;
            end
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    last_nxt = (dsss_nxt == D_LAST) && (rlss_nxt == R_LAST) && (state_nxt == RUN || out_last);
  end

endmodule

// File: tb/tb_spare_signal_generator.sv
// Directed bench for spare_signal_generator against an independently enumerated pair table.
// Early-stop scenario is compiled in when SPARE_GEN_EARLY_STOP_EN is defined.
module tb_spare_signal_generator;
  import bira_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  out_ready;
  logic [DSSS_WIDTH-1:0] DSSS;
  logic [RLSS_WIDTH-1:0] RLSS;
  logic                  out_valid;
  logic                  out_last;
  logic [PAIR_IDX_W-1:0] pair_idx;
  logic                  busy;
  logic                  done;
`ifdef SPARE_GEN_EARLY_STOP_EN
  logic                  stop;
  logic                  stopped;
`endif

  int vectors    = 0;
  int miscompares = 0;

  logic [DSSS_WIDTH-1:0] ref_d [NUM_PAIRS];
  logic [RLSS_WIDTH-1:0] ref_r [NUM_PAIRS];

  spare_signal_generator dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .out_ready(out_ready),
`ifdef SPARE_GEN_EARLY_STOP_EN
    .stop     (stop),
    .stopped  (stopped),
`endif
    .DSSS     (DSSS),
    .RLSS     (RLSS),
    .out_valid(out_valid),
    .out_last (out_last),
    .pair_idx (pair_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Brute-force reference: ascending scan filtered by popcount, RLSS innermost.
  task automatic build_reference();
    int k = 0;
    for (int d = 0; d < (1 << DSSS_WIDTH); d++) begin
      if ($countones(d) == DSSS_SET_BITS) begin
        for (int r = 0; r < (1 << RLSS_WIDTH); r++) begin
          if ($countones(r) == RLSS_SET_BITS) begin
            ref_d[k] = DSSS_WIDTH'(d);
            ref_r[k] = RLSS_WIDTH'(r);
            k++;
          end
        end
      end
    end
  endtask

  task automatic start_sweep();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
`ifdef SPARE_GEN_EARLY_STOP_EN
    stop = 1'b0;
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if ({out_valid, busy, done, out_last, DSSS, RLSS, pair_idx} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state got v=%b b=%b d=%b l=%b DSSS=%h RLSS=%h idx=%0d expected all zero",
               out_valid, busy, done, out_last, DSSS, RLSS, pair_idx);
    end
`ifdef SPARE_GEN_EARLY_STOP_EN
    vectors++;
    if (stopped !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_stopped got %b expected 0", stopped);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid, busy, done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset got v/b/d=%b%b%b expected 000", out_valid, busy, done);
    end
  endtask

  task automatic test_first_pairs();
    out_ready = 1'b1;
    start_sweep();
    vectors++;
    if ({out_valid, busy, DSSS, RLSS, pair_idx} !== {1'b1, 1'b1, 8'h0F, 4'h3, 9'd0}) begin
      miscompares++;
      $display("[TB] FAIL first_pair got v=%b b=%b DSSS=%h RLSS=%h idx=%0d expected 1 1 0f 3 0",
               out_valid, busy, DSSS, RLSS, pair_idx);
    end
    @(negedge clk);
    vectors++;
    if ({out_valid, DSSS, RLSS, pair_idx} !== {1'b1, 8'h0F, 4'h5, 9'd1}) begin
      miscompares++;
      $display("[TB] FAIL second_pair got v=%b DSSS=%h RLSS=%h idx=%0d expected 1 0f 5 1",
               out_valid, DSSS, RLSS, pair_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_sweep();
    out_ready = 1'b1;
    start_sweep();
    for (int k = 0; k < NUM_PAIRS; k++) begin
      vectors++;
      if ({out_valid, busy, out_last, done, DSSS, RLSS, pair_idx} !==
          {1'b1, 1'b1, (k == NUM_PAIRS - 1), 1'b0, ref_d[k], ref_r[k], PAIR_IDX_W'(k)}) begin
        miscompares++;
        $display("[TB] FAIL sweep_pair_%0d got v=%b b=%b l=%b d=%b DSSS=%h RLSS=%h idx=%0d expected DSSS=%h RLSS=%h",
                 k, out_valid, busy, out_last, done, DSSS, RLSS, pair_idx, ref_d[k], ref_r[k]);
      end
      @(negedge clk);
    end
    vectors++;
    if ({out_valid, busy, done} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL sweep_done_pulse got v/b/d=%b%b%b expected 001", out_valid, busy, done);
    end
    @(negedge clk);
    vectors++;
    if ({out_valid, busy, done, DSSS, RLSS, pair_idx} !== {3'b000, 8'hF0, 4'hC, 9'd419}) begin
      miscompares++;
      $display("[TB] FAIL sweep_after_done got v/b/d=%b%b%b DSSS=%h RLSS=%h idx=%0d expected 000 f0 c 419",
               out_valid, busy, done, DSSS, RLSS, pair_idx);
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    int cyc = 0;
    out_ready = 1'b0;
    start_sweep();
    while (k < NUM_PAIRS && cyc < 4000) begin
      vectors++;
      if ({out_valid, DSSS, RLSS, pair_idx, out_last} !==
          {1'b1, ref_d[k], ref_r[k], PAIR_IDX_W'(k), (k == NUM_PAIRS - 1)}) begin
        miscompares++;
        $display("[TB] FAIL backpressure_pair_%0d got v=%b DSSS=%h RLSS=%h idx=%0d l=%b expected DSSS=%h RLSS=%h",
                 k, out_valid, DSSS, RLSS, pair_idx, out_last, ref_d[k], ref_r[k]);
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_ready) k++;
      cyc++;
      @(negedge clk);
    end
    vectors++;
    if (k != NUM_PAIRS) begin
      miscompares++;
      $display("[TB] FAIL backpressure_timeout got %0d handshakes expected %0d", k, NUM_PAIRS);
    end
    vectors++;
    if ({out_valid, done} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL backpressure_done got v/d=%b%b expected 01", out_valid, done);
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sweep();
    out_ready = 1'b1;
    start_sweep();
    repeat (100) @(negedge clk);
    vectors++;
    if ({DSSS, RLSS, pair_idx} !== {ref_d[100], ref_r[100], 9'd100}) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_pair got DSSS=%h RLSS=%h idx=%0d expected %h %h 100",
               DSSS, RLSS, pair_idx, ref_d[100], ref_r[100]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({out_valid, busy, done, out_last, DSSS, RLSS, pair_idx} !== '0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_state got v=%b b=%b d=%b l=%b DSSS=%h RLSS=%h idx=%0d expected all zero",
               out_valid, busy, done, out_last, DSSS, RLSS, pair_idx);
    end
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({busy, done} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL mid_reset_no_done got b/d=%b%b expected 00", busy, done);
      end
    end
    start_sweep();
    vectors++;
    if ({out_valid, DSSS, RLSS, pair_idx} !== {1'b1, 8'h0F, 4'h3, 9'd0}) begin
      miscompares++;
      $display("[TB] FAIL restart_pair got v=%b DSSS=%h RLSS=%h idx=%0d expected 1 0f 3 0",
               out_valid, DSSS, RLSS, pair_idx);
    end
  endtask

  task automatic test_start_ignored();
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if ({out_valid, busy, DSSS, RLSS, pair_idx} !== {1'b1, 1'b1, ref_d[6], ref_r[6], 9'd6}) begin
      miscompares++;
      $display("[TB] FAIL start_in_run got v=%b b=%b DSSS=%h RLSS=%h idx=%0d expected 1 1 %h %h 6",
               out_valid, busy, DSSS, RLSS, pair_idx, ref_d[6], ref_r[6]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_start_with_reset();
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    vectors++;
    if ({out_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL start_with_reset got v/b=%b%b expected 00", out_valid, busy);
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid, busy, pair_idx} !== {2'b00, 9'd0}) begin
      miscompares++;
      $display("[TB] FAIL idle_after_start_reset got v/b=%b%b idx=%0d expected 00 0", out_valid, busy, pair_idx);
    end
  endtask

`ifdef SPARE_GEN_EARLY_STOP_EN
  task automatic test_early_stop();
    out_ready = 1'b1;
    start_sweep();
    repeat (37) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    vectors++;
    if ({out_valid, busy, done, stopped} !== 4'b0011) begin
      miscompares++;
      $display("[TB] FAIL stop_entry got v/b/d/s=%b%b%b%b expected 0011", out_valid, busy, done, stopped);
    end
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, done, stopped} !== 3'b001) begin
        miscompares++;
        $display("[TB] FAIL stop_hold got v/d/s=%b%b%b expected 001", out_valid, done, stopped);
      end
    end
    start_sweep();
    vectors++;
    if ({out_valid, stopped, DSSS, RLSS} !== {2'b10, 8'h0F, 4'h3}) begin
      miscompares++;
      $display("[TB] FAIL stop_cleared got v/s=%b%b DSSS=%h RLSS=%h expected 10 0f 3",
               out_valid, stopped, DSSS, RLSS);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    build_reference();
    test_reset();
    test_first_pairs();
    test_full_sweep();
    test_backpressure();
    test_reset_mid_sweep();
    test_start_ignored();
    test_start_with_reset();
`ifdef SPARE_GEN_EARLY_STOP_EN
    test_early_stop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
